fb_scan_reader: RTL and testbench

FB_SCAN_READER -- requirements
Module: fb_scan_reader

---
 rtl/fb_pkg.sv | 30 +++
 rtl/fb_sync_edge.sv | 21 ++
 rtl/fb_scan_reader.sv | 141 ++++++++++++++
 tb/tb_fb_scan_reader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer scan reader: FSM states, bus widths
// and the SRAM-word-to-colour mapping.
package fb_pkg;

    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned COLOR_W = 10;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned NIB_W   = 4;

    // Bit positions of the 4-bit colour nibbles inside a 16-bit SRAM pixel word
    localparam int unsigned RED_LSB   = 12;
    localparam int unsigned GREEN_LSB = 8;
    localparam int unsigned BLUE_LSB  = 4;

    localparam logic [COLOR_W-1:0] COLOR_BLACK = '0;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_HANDOFF  = 2'd1,
        ST_GRANT    = 2'd2,
        ST_RECLAIM  = 2'd3
    } fb_state_t;

    // Expand a 4-bit nibble to the top bits of a colour channel
    function automatic logic [COLOR_W-1:0] nibble_to_color(input logic [NIB_W-1:0] nib);
        return {nib, (COLOR_W-NIB_W)'(0)};
    endfunction

endpackage

// File: rtl/fb_sync_edge.sv
// Registered falling-edge detector for an active-low sync; the pulse is one clock wide.
module fb_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sync_n,
    output logic fall
);

    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_q <= sync_n;
            fall   <= sync_q & ~sync_n;
        end
    end

endmodule

// File: rtl/fb_scan_reader.sv
// Frame-buffer SRAM scan reader: streams pixels to the VGA path and hands the SRAM bus
// to a writer during sync windows, reclaiming it when the window closes.
module fb_scan_reader
    import fb_pkg::*;
(
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [COORD_W-1:0]  iCoord_X,
    input  logic [COORD_W-1:0]  iCoord_Y,
    input  logic                iH_SYNC_N,
    input  logic                iV_SYNC_N,
    input  logic                iWr_Req,
    input  logic                iWr_En,
    input  logic [ADDR_W-1:0]   iWr_Addr,
    input  logic [DATA_W-1:0]   iWr_Data,
    output logic                oWr_Gnt,
    output logic                oWr_Abort,
    output logic [DATA_W-1:0]   oWr_Rd_Data,
    output logic [ADDR_W-1:0]   oSRAM_ADDR,
    output logic                oSRAM_WE_N,
    output logic [DATA_W-1:0]   oSRAM_DQ,
    output logic                oSRAM_DQ_OE,
    input  logic [DATA_W-1:0]   iSRAM_DQ,
    output logic [COLOR_W-1:0]  oRed,
    output logic [COLOR_W-1:0]  oGreen,
    output logic [COLOR_W-1:0]  oBlue,
    output logic [15:0]         oFrame_Cnt
);

    fb_state_t state, next_state;

    logic               sync_window;
    logic               wr_txn;
    logic               scan_q;
    logic               rd_pending;
    logic               v_fall;
    logic [ADDR_W-1:0]  addr_d;
    logic               we_n_d;
    logic [DATA_W-1:0]  dq_d;
    logic               oe_d;
    logic               unused_bits;

    assign sync_window = ~iH_SYNC_N | ~iV_SYNC_N;
    assign wr_txn      = (state == ST_GRANT) & iWr_Req;
    assign unused_bits = ^{iCoord_X[0], iCoord_Y[0], iSRAM_DQ[BLUE_LSB-1:0]};

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= ST_SCAN;
        else      state <= next_state;
    end

    // Writer only gets the bus if its request is up while the window is open
    always_comb begin
        next_state = state;
        case (state)
            ST_SCAN:    if (sync_window && iWr_Req) next_state = ST_HANDOFF;
            ST_HANDOFF: next_state = sync_window ? ST_GRANT : ST_RECLAIM;
            ST_GRANT:   if (!sync_window) next_state = ST_RECLAIM;
            ST_RECLAIM: next_state = ST_SCAN;
            default:    next_state = ST_SCAN;
        endcase
    end

    // Next SRAM bus value; HANDOFF/RECLAIM and idle GRANT keep the bus released
    always_comb begin
        addr_d = oSRAM_ADDR;
        we_n_d = 1'b1;
        dq_d   = oSRAM_DQ;
        oe_d   = 1'b0;
        if (state == ST_SCAN) begin
            addr_d = {iCoord_X[COORD_W-1:1], iCoord_Y[COORD_W-1:1]};
        end else if (wr_txn) begin
            addr_d = iWr_Addr;
            we_n_d = ~iWr_En;
            dq_d   = iWr_Data;
            oe_d   = iWr_En;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oSRAM_ADDR  <= '0;
            oSRAM_WE_N  <= 1'b1;
            oSRAM_DQ    <= '0;
            oSRAM_DQ_OE <= 1'b0;
        end else begin
            oSRAM_ADDR  <= addr_d;
            oSRAM_WE_N  <= we_n_d;
            oSRAM_DQ    <= dq_d;
            oSRAM_DQ_OE <= oe_d;
        end
    end

    // scan_q marks that the word now on iSRAM_DQ came from a scan address
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            scan_q <= 1'b0;
            oRed   <= COLOR_BLACK;
            oGreen <= COLOR_BLACK;
            oBlue  <= COLOR_BLACK;
        end else begin
            scan_q <= (state == ST_SCAN);
            if (state == ST_SCAN && next_state == ST_SCAN && scan_q) begin
                oRed   <= nibble_to_color(iSRAM_DQ[RED_LSB   +: NIB_W]);
                oGreen <= nibble_to_color(iSRAM_DQ[GREEN_LSB +: NIB_W]);
                oBlue  <= nibble_to_color(iSRAM_DQ[BLUE_LSB  +: NIB_W]);
            end else begin
                oRed   <= COLOR_BLACK;
                oGreen <= COLOR_BLACK;
                oBlue  <= COLOR_BLACK;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oWr_Gnt     <= 1'b0;
            oWr_Abort   <= 1'b0;
            rd_pending  <= 1'b0;
            oWr_Rd_Data <= '0;
        end else begin
            oWr_Gnt    <= (next_state == ST_GRANT);
            oWr_Abort  <= (state == ST_GRANT) && (next_state == ST_RECLAIM) && iWr_Req;
            rd_pending <= wr_txn & ~iWr_En;
            if (rd_pending) oWr_Rd_Data <= iSRAM_DQ;
        end
    end

    fb_sync_edge u_vsync_edge (
        .clk    (iCLK),
        .rst    (iRST),
        .sync_n (iV_SYNC_N),
        .fall   (v_fall)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)        oFrame_Cnt <= '0;
        else if (v_fall) oFrame_Cnt <= oFrame_Cnt + 16'd1;
    end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader with a behavioural asynchronous SRAM attached.
module tb_fb_scan_reader;
    import fb_pkg::*;

    logic               iCLK;
    logic               iRST;
    logic [9:0]         iCoord_X, iCoord_Y;
    logic               iH_SYNC_N, iV_SYNC_N;
    logic               iWr_Req, iWr_En;
    logic [17:0]        iWr_Addr;
    logic [15:0]        iWr_Data;
    logic               oWr_Gnt, oWr_Abort;
    logic [15:0]        oWr_Rd_Data;
    logic [17:0]        oSRAM_ADDR;
    logic               oSRAM_WE_N;
    logic [15:0]        oSRAM_DQ;
    logic               oSRAM_DQ_OE;
    logic [15:0]        iSRAM_DQ;
    logic [9:0]         oRed, oGreen, oBlue;
    logic [15:0]        oFrame_Cnt;

    logic [15:0] mem [0:262143];
    int vectors = 0;
    int miscompares = 0;

    fb_scan_reader dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iCoord_X    (iCoord_X),
        .iCoord_Y    (iCoord_Y),
        .iH_SYNC_N   (iH_SYNC_N),
        .iV_SYNC_N   (iV_SYNC_N),
        .iWr_Req     (iWr_Req),
        .iWr_En      (iWr_En),
        .iWr_Addr    (iWr_Addr),
        .iWr_Data    (iWr_Data),
        .oWr_Gnt     (oWr_Gnt),
        .oWr_Abort   (oWr_Abort),
        .oWr_Rd_Data (oWr_Rd_Data),
        .oSRAM_ADDR  (oSRAM_ADDR),
        .oSRAM_WE_N  (oSRAM_WE_N),
        .oSRAM_DQ    (oSRAM_DQ),
        .oSRAM_DQ_OE (oSRAM_DQ_OE),
        .iSRAM_DQ    (iSRAM_DQ),
        .oRed        (oRed),
        .oGreen      (oGreen),
        .oBlue       (oBlue),
        .oFrame_Cnt  (oFrame_Cnt)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Asynchronous-read SRAM; a write commits at the end of the cycle it is driven
    assign iSRAM_DQ = mem[oSRAM_ADDR];
    always @(posedge iCLK) begin
        if (!oSRAM_WE_N && oSRAM_DQ_OE) mem[oSRAM_ADDR] <= oSRAM_DQ;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        iRST = 1'b0;
        iCoord_X = '0; iCoord_Y = '0;
        iH_SYNC_N = 1'b1; iV_SYNC_N = 1'b1;
        iWr_Req = 1'b0; iWr_En = 1'b0;
        iWr_Addr = '0; iWr_Data = '0;
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        mem[18'h00A03] = 16'hF0A0;

        #1 iRST = 1'b1;
        #1;
        chk("rst_we_n",  32'(oSRAM_WE_N),  32'h1);
        chk("rst_oe",    32'(oSRAM_DQ_OE), 32'h0);
        chk("rst_addr",  32'(oSRAM_ADDR),  32'h0);
        chk("rst_gnt",   32'(oWr_Gnt),     32'h0);
        chk("rst_frame", 32'(oFrame_Cnt),  32'h0);
        chk("rst_red",   32'(oRed),        32'h0);
        step(2);
        iRST = 1'b0;

        // Scan pixel: coord (10,6) -> address {5,3}
        iCoord_X = 10'd10; iCoord_Y = 10'd6;
        step(1);
        chk("scan_addr", 32'(oSRAM_ADDR), 32'h00A03);
        chk("scan_we_n", 32'(oSRAM_WE_N), 32'h1);
        step(1);
        chk("scan_red",   32'(oRed),   32'h3C0);
        chk("scan_green", 32'(oGreen), 32'h000);
        chk("scan_blue",  32'(oBlue),  32'h280);

        // Handoff then write into granted bus
        iH_SYNC_N = 1'b0; iWr_Req = 1'b1; iWr_En = 1'b1;
        iWr_Addr = 18'h14078; iWr_Data = 16'hFFFF;
        step(1);
        chk("handoff_gnt",  32'(oWr_Gnt),    32'h0);
        chk("handoff_we_n", 32'(oSRAM_WE_N), 32'h1);
        chk("handoff_red",  32'(oRed),       32'h0);
        step(1);
        chk("grant_gnt",  32'(oWr_Gnt),     32'h1);
        chk("grant_we_n", 32'(oSRAM_WE_N),  32'h1);
        chk("grant_oe",   32'(oSRAM_DQ_OE), 32'h0);
        step(1);
        chk("wr_addr", 32'(oSRAM_ADDR),  32'h14078);
        chk("wr_we_n", 32'(oSRAM_WE_N),  32'h0);
        chk("wr_oe",   32'(oSRAM_DQ_OE), 32'h1);
        chk("wr_dq",   32'(oSRAM_DQ),    32'hFFFF);
        chk("grant_red", 32'(oRed),      32'h0);

        // Write 1234 to 0x123 then read it back
        iWr_Addr = 18'h00123; iWr_Data = 16'h1234;
        step(1);
        chk("wr2_addr", 32'(oSRAM_ADDR), 32'h00123);
        chk("wr2_we_n", 32'(oSRAM_WE_N), 32'h0);
        iWr_En = 1'b0;
        step(1);
        chk("rd_we_n", 32'(oSRAM_WE_N),  32'h1);
        chk("rd_oe",   32'(oSRAM_DQ_OE), 32'h0);
        chk("rd_hold", 32'(oWr_Rd_Data), 32'h0);
        step(1);
        chk("rd_data", 32'(oWr_Rd_Data), 32'h1234);

        // Window closes while the writer still requests
        iH_SYNC_N = 1'b1;
        step(1);
        chk("abort_pulse", 32'(oWr_Abort),   32'h1);
        chk("abort_gnt",   32'(oWr_Gnt),     32'h0);
        chk("abort_oe",    32'(oSRAM_DQ_OE), 32'h0);
        iWr_Req = 1'b0;
        step(1);
        chk("abort_end", 32'(oWr_Abort), 32'h0);
        step(1);
        chk("reclaim_scan_addr", 32'(oSRAM_ADDR), 32'h00A03);

        // Request rising as the window closes must not leave SCAN
        iH_SYNC_N = 1'b0;
        step(1);
        iH_SYNC_N = 1'b1; iWr_Req = 1'b1;
        step(2);
        chk("late_req_gnt",  32'(oWr_Gnt),    32'h0);
        chk("late_req_addr", 32'(oSRAM_ADDR), 32'h00A03);
        iWr_Req = 1'b0;

        // Window closes during HANDOFF
        iH_SYNC_N = 1'b0; iWr_Req = 1'b1;
        step(1);
        iH_SYNC_N = 1'b1;
        step(1);
        chk("ho_close_gnt",   32'(oWr_Gnt),   32'h0);
        chk("ho_close_abort", 32'(oWr_Abort), 32'h0);
        iWr_Req = 1'b0;
        step(2);

        // Two VSYNC falls, the first held low several cycles
        iV_SYNC_N = 1'b0; step(4);
        iV_SYNC_N = 1'b1; step(1);
        iV_SYNC_N = 1'b0; step(1);
        iV_SYNC_N = 1'b1; step(3);
        chk("frame_two", 32'(oFrame_Cnt), 32'h2);

        // Reset in the middle of a granted write
        iH_SYNC_N = 1'b0; iWr_Req = 1'b1; iWr_En = 1'b1;
        iWr_Addr = 18'h14078; iWr_Data = 16'h5A5A;
        step(3);
        chk("pre_rst_we_n", 32'(oSRAM_WE_N), 32'h0);
        #2 iRST = 1'b1;
        #1;
        chk("mid_rst_we_n",  32'(oSRAM_WE_N),  32'h1);
        chk("mid_rst_oe",    32'(oSRAM_DQ_OE), 32'h0);
        chk("mid_rst_addr",  32'(oSRAM_ADDR),  32'h0);
        chk("mid_rst_dq",    32'(oSRAM_DQ),    32'h0);
        chk("mid_rst_gnt",   32'(oWr_Gnt),     32'h0);
        chk("mid_rst_rd",    32'(oWr_Rd_Data), 32'h0);
        chk("mid_rst_frame", 32'(oFrame_Cnt),  32'h0);
        iWr_Req = 1'b0; iWr_En = 1'b0; iH_SYNC_N = 1'b1;
        step(2);
        iRST = 1'b0;
        step(2);

        // Frame counter wrap
        for (int i = 0; i < 65535; i++) begin
            iV_SYNC_N = 1'b0; step(1);
            iV_SYNC_N = 1'b1; step(1);
        end
        step(2);
        chk("frame_ffff", 32'(oFrame_Cnt), 32'hFFFF);
        iV_SYNC_N = 1'b0; step(1);
        iV_SYNC_N = 1'b1; step(3);
        chk("frame_wrap", 32'(oFrame_Cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
